// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, quarter-period offset and sequencer states for the I/Q DDS.
`default_nettype none

package dds_pkg;
  localparam int PHASE_W     = 16;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 5;
  localparam int QUARTER_OFS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_Q = 2'd2,
    WR   = 2'd3
  } dds_state_t;
endpackage

`default_nettype wire

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase accumulator with a held tuning word; rev 1.0.
`default_nettype none

module dds_phase_acc
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load_tune,
  input  logic               advance,
  input  logic [PHASE_W-1:0] tune,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] tune_r;

  // The advance uses the tuning word held before this edge; a new word
  // loaded on the same edge only affects the following sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      tune_r <= '0;
    end else begin
      if (clear) begin
        phase <= '0;
      end else if (advance) begin
        phase <= phase + tune_r;
      end
      if (load_tune) begin
        tune_r <= tune;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iq_dds_ctrl.sv
// iq_dds_ctrl: time-multiplexes a single-port cosine ROM into registered I/Q samples; rev 1.0.
`default_nettype none

module iq_dds_ctrl
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] tune,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  i_data,
  output logic [DATA_W-1:0]  q_data,
  output logic               sample_valid,
  output logic               busy
);

  dds_state_t         state;
  logic               stop_pend;
  logic [DATA_W-1:0]  i_reg;
  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  addr_i;
  logic               acc_clear;
  logic               acc_load;
  logic               acc_adv;
  logic               unused_phase_lsbs;

  assign acc_clear = (state == IDLE) && start && !stop;
  assign acc_load  = acc_clear || (state == WR);
  assign acc_adv   = (state == WR);

  dds_phase_acc u_phase_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (acc_clear),
    .load_tune (acc_load),
    .advance   (acc_adv),
    .tune      (tune),
    .phase     (phase)
  );

  assign addr_i            = phase[PHASE_W-1 -: ADDR_W];
  assign unused_phase_lsbs = ^phase[PHASE_W-ADDR_W-1:0];
  assign busy              = (state != IDLE);

  // Q reads a quarter period behind I: cos(phase - 90 deg) = sin(phase).
  always_comb begin
    rom_addr = '0;
    case (state)
      RD_I:    rom_addr = addr_i;
      RD_Q:    rom_addr = addr_i - ADDR_W'(QUARTER_OFS);
      default: rom_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      stop_pend    <= 1'b0;
      i_reg        <= '0;
      i_data       <= '0;
      q_data       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if ((state != IDLE) && stop) begin
        stop_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start && !stop) begin
            stop_pend <= 1'b0;
            state     <= RD_I;
          end
        end
        RD_I: state <= RD_Q;
        RD_Q: begin
          i_reg <= rom_data;
          state <= WR;
        end
        WR: begin
          i_data       <= i_reg;
          q_data       <= rom_data;
          sample_valid <= 1'b1;
          state        <= (stop_pend || stop) ? IDLE : RD_I;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iq_dds_ctrl.sv
// tb_iq_dds_ctrl: scoreboard bench with a behavioural one-cycle ROM beside the DUT.
`default_nettype none

module tb_iq_dds_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] tune = 16'h0000;
  logic [5:0]  rom_addr;
  logic [4:0]  rom_data = 5'd0;
  logic [4:0]  i_data;
  logic [4:0]  q_data;
  logic        sample_valid;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [5:0] hist [0:2] = '{6'd0, 6'd0, 6'd0};

  typedef struct {
    logic [5:0] ia;
    logic [5:0] qa;
    logic [4:0] iv;
    logic [4:0] qv;
    int         cyc;
  } exp_t;

  exp_t sbq [$];
  exp_t last_e;

  iq_dds_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .tune         (tune),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .i_data       (i_data),
    .q_data       (q_data),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Table chosen so that k, k-16, k+16 and k+32 all read different values.
  function automatic logic [4:0] rom_f(input logic [5:0] k);
    return k[4:0] ^ {k[5], k[5], 3'b000} ^ 5'd3;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom_f(rom_addr);
    hist[0]  <= rom_addr;
    hist[1]  <= hist[0];
    hist[2]  <= hist[1];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every sample pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && sample_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sample: got i=%0d q=%0d expected no pulse (t=%0t)", i_data, q_data, $time);
      end else begin
        e = sbq.pop_front();
        chk("i_addr", int'(hist[2]), int'(e.ia));
        chk("q_addr", int'(hist[1]), int'(e.qa));
        chk("i_data", int'(i_data), int'(e.iv));
        chk("q_data", int'(q_data), int'(e.qv));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // Run nsamp samples from a start held for 'hold' cycles, stopping during the last RD_Q.
  task automatic go(input logic [15:0] t, input logic [15:0] t2, input int nsamp, input int hold);
    logic [15:0] ph;
    logic [15:0] tr;
    int n0;
    exp_t e;
    @(negedge clk);
    tune  = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    n0   = cyc;
    tune = t2;
    ph = 16'h0000;
    tr = t;
    for (int j = 0; j < nsamp; j++) begin
      e.ia  = ph[15:10];
      e.qa  = e.ia - 6'd16;
      e.iv  = rom_f(e.ia);
      e.qv  = rom_f(e.qa);
      e.cyc = n0 + 3 + 3 * j;
      sbq.push_back(e);
      ph = ph + tr;
      tr = t2;
    end
    last_e = e;
    if (hold > 1) begin
      repeat (hold - 1) @(posedge clk);
      #1;
    end
    start = 1'b0;
    while (cyc < n0 + 1 + 3 * (nsamp - 1)) begin
      @(posedge clk);
      #1;
    end
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_at_last_pulse", int'(busy), 0);
    chk("valid_at_stop", int'(sample_valid), 1);
    repeat (5) @(negedge clk);
    chk("busy_after_stop", int'(busy), 0);
    chk("i_hold", int'(i_data), int'(last_e.iv));
    chk("q_hold", int'(q_data), int'(last_e.qv));
  endtask

  initial begin
    #12;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_i_data", int'(i_data), 0);
    chk("rst_q_data", int'(q_data), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    go(16'h0400, 16'h0400, 5, 1);   // unit step
    go(16'hFC00, 16'hFC00, 4, 1);   // downward wrap-around

    // Asynchronous reset in the middle of RD_Q.
    @(negedge clk);
    tune  = 16'h0400;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    chk("rdq_addr_before_reset", int'(rom_addr), 48);
    reset = 1'b1;
    #1;
    chk("async_rom_addr", int'(rom_addr), 0);
    chk("async_i_data", int'(i_data), 0);
    chk("async_q_data", int'(q_data), 0);
    chk("async_valid", int'(sample_valid), 0);
    chk("async_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_after_reset", int'(busy), 0);

    go(16'h0000, 16'h0000, 3, 1);   // zero tune
    go(16'h0400, 16'h0800, 3, 5);   // tune change mid-run, start held while busy

    // start and stop together in IDLE.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    chk("start_stop_idle", int'(busy), 0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
